// File: rtl/dcache_sa_wt.sv
// dcache_sa_wt: set-associative, write-through, no-write-allocate data cache
// for the M stage. Read misses fill a whole line word by word over a
// variable-latency request/ack port; stores are always written through.
// Optional feature macro: DCACHE_PERF_CNT_EN adds ReadHitCnt/ReadMissCnt.
module dcache_sa_wt #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int SETS           = 8,
    parameter int WAYS           = 2,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] WD,
    input  logic                  WE0,
    input  logic                  WE1,
    input  logic                  WE2,
    input  logic                  WE3,
    output logic [DATA_WIDTH-1:0] RD,
    output logic                  hit,
    output logic                  StallM,
    output logic                  MemReq,
    output logic                  MemWE,
    output logic [ADDR_WIDTH-1:0] MemA,
    output logic [DATA_WIDTH-1:0] MemWD,
    output logic [3:0]            MemBE,
    input  logic [DATA_WIDTH-1:0] MemRD,
`ifdef DCACHE_PERF_CNT_EN
    output logic [31:0]           ReadHitCnt,
    output logic [31:0]           ReadMissCnt,
`endif
    input  logic                  MemAck
);

    localparam int OFF_W    = $clog2(WORDS_PER_LINE);
    localparam int WORD_W   = (OFF_W > 0) ? OFF_W : 1;
    localparam int IDX_W    = $clog2(SETS);
    localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int LINE_LSB = 2 + OFF_W;
    localparam int BASE_W   = ADDR_WIDTH - LINE_LSB;
    localparam int TAG_W    = BASE_W - IDX_W;

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    state_t                  state_q, state_d;
    logic                    req_q, req_d, we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wd_q, wd_d;
    logic [3:0]              be_q, be_d;
    logic [WORD_W-1:0]       cnt_q, cnt_d;
    logic [BASE_W-1:0]       base_q, base_d;
    logic [WAY_W-1:0]        victim_q, victim_d;

    logic [WAYS-1:0]         valid_q [SETS];
    logic [WAY_W-1:0]        rr_q    [SETS];
    logic [TAG_W-1:0]        tag_q   [SETS][WAYS];
    logic [DATA_WIDTH-1:0]   data_q  [SETS][WAYS][WORDS_PER_LINE];

    logic [ADDR_WIDTH-3:0]   lk_line;
    logic [IDX_W-1:0]        lk_set;
    logic [TAG_W-1:0]        lk_tag;
    logic [WORD_W-1:0]       lk_word;
    logic                    lk_hit, vict_found;
    logic [WAY_W-1:0]        lk_way, vict_sel;
    logic                    fill_wr, fill_done, merge_wr;
    logic [IDX_W-1:0]        fset;

    assign fset = base_q[IDX_W-1:0];

    // Tag lookup: pipeline address in IDLE, held store address in WRITE.
    always_comb begin
        lk_line    = (state_q == IDLE) ? A[ADDR_WIDTH-1:2] : addr_q[ADDR_WIDTH-1:2];
        lk_set     = lk_line[OFF_W +: IDX_W];
        lk_tag     = lk_line[ADDR_WIDTH-3 -: TAG_W];
        lk_word    = (WORDS_PER_LINE > 1) ? lk_line[WORD_W-1:0] : '0;
        lk_hit     = 1'b0;
        lk_way     = '0;
        vict_found = 1'b0;
        vict_sel   = rr_q[lk_set];
        for (int w = 0; w < WAYS; w++) begin
            if (!lk_hit && valid_q[lk_set][w] && (tag_q[lk_set][w] == lk_tag)) begin
                lk_hit = 1'b1;
                lk_way = WAY_W'(w);
            end
            if (!vict_found && !valid_q[lk_set][w]) begin
                vict_found = 1'b1;
                vict_sel   = WAY_W'(w);
            end
        end
    end

    assign hit = (state_q == IDLE) && lk_hit;
    assign RD  = hit ? data_q[lk_set][lk_way][lk_word] : '0;

    // Next-state, request register updates and stall generation.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wd_d      = wd_q;
        be_d      = be_q;
        cnt_d     = cnt_q;
        base_d    = base_q;
        victim_d  = victim_q;
        StallM    = 1'b0;
        fill_wr   = 1'b0;
        fill_done = 1'b0;
        merge_wr  = 1'b0;
        case (state_q)
            IDLE: begin
                if (MemWrite) begin
                    StallM  = 1'b1;
                    state_d = WRITE;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = A & ~ADDR_WIDTH'(3);
                    wd_d    = WD;
                    be_d    = {WE3, WE2, WE1, WE0};
                end else if (MemRead && !lk_hit) begin
                    StallM   = 1'b1;
                    state_d  = FILL;
                    req_d    = 1'b1;
                    we_d     = 1'b0;
                    base_d   = A[ADDR_WIDTH-1:LINE_LSB];
                    addr_d   = {A[ADDR_WIDTH-1:LINE_LSB], LINE_LSB'(0)};
                    cnt_d    = '0;
                    victim_d = vict_sel;
                end
            end
            FILL: begin
                StallM = 1'b1;
                if (MemAck) begin
                    fill_wr = 1'b1;
                    if (cnt_q == WORD_W'(WORDS_PER_LINE - 1)) begin
                        fill_done = 1'b1;
                        state_d   = IDLE;
                        req_d     = 1'b0;
                    end else begin
                        cnt_d  = cnt_q + 1'b1;
                        addr_d = addr_q + ADDR_WIDTH'(4);
                    end
                end
            end
            WRITE: begin
                StallM = ~MemAck;
                if (MemAck) begin
                    merge_wr = lk_hit;
                    state_d  = IDLE;
                    req_d    = 1'b0;
                    we_d     = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and memory-port request registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wd_q    <= '0;
            be_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            be_q    <= be_d;
            cnt_q   <= cnt_d;
        end
    end

    // Fill target line/way, only meaningful while a fill is in flight.
    always_ff @(posedge CLK) begin
        base_q   <= base_d;
        victim_q <= victim_d;
    end

    // Valid bits and round-robin pointers; a line turns valid only after its last word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else if (fill_done) begin
            valid_q[fset][victim_q] <= 1'b1;
            rr_q[fset] <= (rr_q[fset] == WAY_W'(WAYS - 1)) ? '0 : rr_q[fset] + 1'b1;
        end
    end

    // Tag and data arrays: fill words land in the victim way, store bytes merge into a resident line.
    always_ff @(posedge CLK) begin
        if (fill_done) begin
            tag_q[fset][victim_q] <= base_q[BASE_W-1:IDX_W];
        end
        if (fill_wr) begin
            data_q[fset][victim_q][cnt_q] <= MemRD;
        end
        if (merge_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    data_q[lk_set][lk_way][lk_word][8*b +: 8] <= wd_q[8*b +: 8];
                end
            end
        end
    end

    assign MemReq = req_q;
    assign MemWE  = we_q;
    assign MemA   = addr_q;
    assign MemWD  = wd_q;
    assign MemBE  = be_q;

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hcnt_q, mcnt_q;

    // Load hit/miss counters, sampled on IDLE load lookups only.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hcnt_q <= '0;
            mcnt_q <= '0;
        end else if ((state_q == IDLE) && MemRead && !MemWrite) begin
            if (lk_hit) hcnt_q <= hcnt_q + 32'd1;
            else        mcnt_q <= mcnt_q + 32'd1;
        end
    end

    assign ReadHitCnt  = hcnt_q;
    assign ReadMissCnt = mcnt_q;
`endif

endmodule

// File: tb/tb_dcache_sa_wt.sv
// Self-checking bench for dcache_sa_wt (default parameters, perf counters off).
// A line-residency model plus a flat memory array predicts every transaction;
// a responder plays the memory with a programmable ack latency.
module tb_dcache_sa_wt;

    localparam int K_HIT  = 0;
    localparam int K_MISS = 1;
    localparam int K_ST   = 2;
    localparam int WPL    = 4;

    logic        CLK = 1'b0;
    logic        RST, MemRead, MemWrite, WE0, WE1, WE2, WE3, MemAck;
    logic [31:0] A, WD, MemRD;
    logic [31:0] RD, MemA, MemWD;
    logic [3:0]  MemBE;
    logic        hit, StallM, MemReq, MemWE;

    dcache_sa_wt dut (
        .CLK(CLK), .RST(RST), .MemRead(MemRead), .MemWrite(MemWrite), .A(A), .WD(WD),
        .WE0(WE0), .WE1(WE1), .WE2(WE2), .WE3(WE3), .RD(RD), .hit(hit), .StallM(StallM),
        .MemReq(MemReq), .MemWE(MemWE), .MemA(MemA), .MemWD(MemWD), .MemBE(MemBE),
        .MemRD(MemRD), .MemAck(MemAck)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int lat    = 0;

    logic [31:0] mem [0:1023];
    bit          mvalid [8][2];
    int          mtag   [8][2];
    int          mrr    [8];

    bit          txn_active = 1'b0;
    bit          txn_done   = 1'b0;
    int          t_kind, tcyc, t_stalls;
    logic [31:0] t_addr, t_wd, t_rd;
    logic [3:0]  t_be;
    logic        t_hit0;
    logic [31:0] addr_log [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int m_find(input logic [31:0] a);
        int s = int'(a[6:4]);
        for (int i = 0; i < 2; i++)
            if (mvalid[s][i] && mtag[s][i] == int'(a[31:7])) return i;
        return -1;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 8; s++) begin
            mrr[s] = 0;
            for (int i = 0; i < 2; i++) begin
                mvalid[s][i] = 1'b0;
                mtag[s][i]   = 0;
            end
        end
    endtask

    // Memory responder: ack arrives lat cycles after the request appears;
    // address and data must not move while a request is waiting.
    logic        r_req = 1'b0, r_ack = 1'b0, r_we;
    logic [31:0] h_a, h_wd;
    logic [3:0]  h_be;
    int          wcnt = 0;
    always @(posedge CLK) begin
        logic acked;
        #2;
        acked = r_req && r_ack;
        if (MemReq && r_req && !acked) begin
            wcnt++;
            chk("hold_MemA", MemA, h_a);
            chk("hold_MemWE", {31'b0, MemWE}, {31'b0, r_we});
            if (MemWE) begin
                chk("hold_MemWD", MemWD, h_wd);
                chk("hold_MemBE", {28'b0, MemBE}, {28'b0, h_be});
            end
        end else begin
            wcnt = 0;
            if (MemReq) begin
                h_a = MemA; h_wd = MemWD; h_be = MemBE; r_we = MemWE;
                addr_log.push_back(MemA);
            end
        end
        MemAck = MemReq && (wcnt == lat);
        MemRD  = MemAck ? mem[MemA[11:2]] : 32'hDEADBEEF;
        r_req  = MemReq;
        r_ack  = MemAck;
    end

    // Cycle-by-cycle comparison of the DUT against the expected transaction shape.
    always @(negedge CLK) begin
        if (txn_active) begin
            if (tcyc == 0) t_hit0 = hit;
            if (StallM === 1'b1) t_stalls++;
            case (t_kind)
                K_HIT: begin
                    chk("hit_hit", {31'b0, hit}, 32'd1);
                    chk("hit_stall", {31'b0, StallM}, 32'd0);
                    chk("hit_req", {31'b0, MemReq}, 32'd0);
                    chk("hit_RD", RD, mem[t_addr[11:2]]);
                    t_rd = RD;
                    txn_active = 1'b0; txn_done = 1'b1;
                end
                K_MISS: begin
                    if (tcyc == 0) begin
                        chk("miss_hit0", {31'b0, hit}, 32'd0);
                        chk("miss_stall0", {31'b0, StallM}, 32'd1);
                        chk("miss_req0", {31'b0, MemReq}, 32'd0);
                    end else if (tcyc < 1 + WPL * (lat + 1)) begin
                        chk("fill_stall", {31'b0, StallM}, 32'd1);
                        chk("fill_req", {31'b0, MemReq}, 32'd1);
                        chk("fill_we", {31'b0, MemWE}, 32'd0);
                        chk("fill_MemA", MemA, (t_addr & ~32'hF) + 32'(4 * ((tcyc - 1) / (lat + 1))));
                    end else begin
                        chk("replay_hit", {31'b0, hit}, 32'd1);
                        chk("replay_stall", {31'b0, StallM}, 32'd0);
                        chk("replay_req", {31'b0, MemReq}, 32'd0);
                        chk("replay_RD", RD, mem[t_addr[11:2]]);
                        t_rd = RD;
                        txn_active = 1'b0; txn_done = 1'b1;
                    end
                end
                default: begin
                    if (tcyc == 0) begin
                        chk("st_stall0", {31'b0, StallM}, 32'd1);
                        chk("st_req0", {31'b0, MemReq}, 32'd0);
                    end else begin
                        chk("st_req", {31'b0, MemReq}, 32'd1);
                        chk("st_we", {31'b0, MemWE}, 32'd1);
                        chk("st_MemA", MemA, t_addr & ~32'h3);
                        chk("st_MemWD", MemWD, t_wd);
                        chk("st_MemBE", {28'b0, MemBE}, {28'b0, t_be});
                        chk("st_stall", {31'b0, StallM}, {31'b0, (tcyc <= lat)});
                        if (tcyc == lat + 1) begin
                            txn_active = 1'b0; txn_done = 1'b1;
                        end
                    end
                end
            endcase
            tcyc++;
        end
    end

    task automatic run_txn();
        int n = 0;
        tcyc = 0; t_stalls = 0; txn_done = 1'b0; txn_active = 1'b1;
        while (!txn_done && n < 300) begin
            @(posedge CLK);
            n++;
        end
        if (!txn_done) begin
            chk("txn_timeout", 32'd0, 32'd1);
            txn_active = 1'b0;
        end
        #1;
    endtask

    task automatic do_load(input logic [31:0] a);
        int w, v, s;
        @(posedge CLK); #1;
        s = int'(a[6:4]);
        w = m_find(a);
        if (w < 0) begin
            v = -1;
            for (int i = 0; i < 2; i++) if (!mvalid[s][i] && v < 0) v = i;
            if (v < 0) v = mrr[s];
            mvalid[s][v] = 1'b1;
            mtag[s][v]   = int'(a[31:7]);
            mrr[s]       = (mrr[s] + 1) % 2;
            t_kind = K_MISS;
        end else begin
            t_kind = K_HIT;
        end
        t_addr = a; MemRead = 1'b1; A = a;
        run_txn();
        MemRead = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        @(posedge CLK); #1;
        for (int b = 0; b < 4; b++)
            if (be[b]) mem[a[11:2]][8*b +: 8] = d[8*b +: 8];
        t_kind = K_ST; t_addr = a; t_wd = d; t_be = be;
        MemWrite = 1'b1; A = a; WD = d;
        {WE3, WE2, WE1, WE0} = be;
        run_txn();
        MemWrite = 1'b0;
        {WE3, WE2, WE1, WE0} = 4'b0;
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        model_clear();
    endtask

    initial begin
        int n;
        RST = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; A = '0; WD = '0;
        {WE3, WE2, WE1, WE0} = 4'b0; MemAck = 1'b0; MemRD = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1111_0000 + 32'(i);
        do_reset();

        // Reset state of every output.
        @(negedge CLK);
        chk("rst_MemReq", {31'b0, MemReq}, 32'd0);
        chk("rst_MemWE", {31'b0, MemWE}, 32'd0);
        chk("rst_StallM", {31'b0, StallM}, 32'd0);
        chk("rst_MemA", MemA, 32'd0);
        chk("rst_MemWD", MemWD, 32'd0);
        chk("rst_MemBE", {28'b0, MemBE}, 32'd0);
        chk("rst_RD", RD, 32'd0);
        chk("rst_hit", {31'b0, hit}, 32'd0);

        // Zero-wait fill of line 0x100.
        addr_log.delete();
        do_load(32'h100);
        chk("L100_stalls", 32'(t_stalls), 32'd5);
        chk("L100_hit0", {31'b0, t_hit0}, 32'd0);
        chk("L100_RD", t_rd, 32'h1111_0040);
        chk("L100_nreq", 32'(addr_log.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk("L100_addr", (i < addr_log.size()) ? addr_log[i] : 32'hFFFF_FFFF, 32'h100 + 32'(4 * i));

        do_load(32'h10C);
        chk("L10C_hit0", {31'b0, t_hit0}, 32'd1);
        chk("L10C_stalls", 32'(t_stalls), 32'd0);
        chk("L10C_RD", t_rd, 32'h1111_0043);

        // Resident store merges one byte.
        do_store(32'h100, 32'h0000_AB00, 4'b0010);
        chk("S100_stalls", 32'(t_stalls), 32'd1);
        do_load(32'h100);
        chk("S100_hit0", {31'b0, t_hit0}, 32'd1);
        chk("S100_RD", t_rd, 32'h1111_AB40);

        // Store miss does not allocate.
        do_store(32'h3A0, 32'hCAFE_F00D, 4'b1111);
        do_load(32'h3A0);
        chk("S3A0_hit0", {31'b0, t_hit0}, 32'd0);
        chk("S3A0_RD", t_rd, 32'hCAFE_F00D);

        // Round-robin eviction in set 0.
        do_reset();
        do_load(32'h000);
        do_load(32'h080);
        do_load(32'h100);
        do_load(32'h080);
        chk("evict_080_hit", {31'b0, t_hit0}, 32'd1);
        do_load(32'h000);
        chk("evict_000_miss", {31'b0, t_hit0}, 32'd0);

        // Three-cycle memory latency.
        lat = 3;
        do_reset();
        do_load(32'h240);
        chk("lat3_stalls", 32'(t_stalls), 32'd17);
        do_store(32'h244, 32'h1234_5678, 4'b1001);
        chk("lat3_st_stalls", 32'(t_stalls), 32'd4);
        do_load(32'h244);
        chk("lat3_merge_hit", {31'b0, t_hit0}, 32'd1);
        chk("lat3_merge_RD", t_rd, 32'h1211_0078);

        // Reset during word 2 of a fill aborts it.
        lat = 0;
        @(posedge CLK); #1;
        MemRead = 1'b1; A = 32'h200;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!(MemReq === 1'b1 && MemA === 32'h208) && n < 50);
        chk("abort_reach_word2", {31'b0, (n < 50)}, 32'd1);
        RST = 1'b1; MemRead = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        model_clear();
        @(negedge CLK);
        chk("abort_MemReq", {31'b0, MemReq}, 32'd0);
        chk("abort_StallM", {31'b0, StallM}, 32'd0);
        do_load(32'h200);
        chk("abort_reload_miss", {31'b0, t_hit0}, 32'd0);
        chk("abort_reload_stalls", 32'(t_stalls), 32'd5);

        repeat (2) @(posedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
